// File: rtl/v_line_sw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : v_line_sw                                                       |
// | Purpose  : Wishbone-selectable pad-column source switch with tristated     |
// |            settle window; optional sticky lock via V_LINE_SW_CFG_LOCK_EN.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module v_line_sw #(
   parameter int          NUM_SRC       = 4,
   parameter int          WIDTH         = 14,
   parameter int          SEL_W         = 4,
   parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
   parameter int          SETTLE_CYCLES = 4,
   parameter int          RESET_SEL     = 0
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [NUM_SRC*WIDTH-1:0] src_o,
   input  logic [NUM_SRC*WIDTH-1:0] src_oe,
   input  logic [WIDTH-1:0]         pad_i,
   output logic [NUM_SRC*WIDTH-1:0] src_i,
   output logic [WIDTH-1:0]         pad_o,
   output logic [WIDTH-1:0]         pad_oe,
   output logic                     busy,
   output logic [SEL_W-1:0]         active_sel
);

   localparam int               c_settle_load = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int               c_cnt_w       = $clog2(c_settle_load + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_load  = c_cnt_w'(c_settle_load);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
   localparam logic [SEL_W:0]   c_num_src     = (SEL_W+1)'(NUM_SRC);
   localparam logic [SEL_W-1:0] c_reset_sel   = SEL_W'(RESET_SEL);
   localparam logic [31:0]      c_stat_adr    = BASE_ADR + 32'd4;

   localparam logic [1:0] c_st_active  = 2'd0;
   localparam logic [1:0] c_st_quiesce = 2'd1;
   localparam logic [1:0] c_st_swap    = 2'd2;

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [SEL_W-1:0]   r_active_sel;
   logic [SEL_W-1:0]   r_pending;
   logic               r_err;
   logic               r_ack;
   logic [31:0]        r_dat;
   logic [WIDTH-1:0]   r_pad_o;
   logic [WIDTH-1:0]   r_pad_oe;

   logic               w_adr_ctrl;
   logic               w_acc;
   logic               w_ctrl_wr;
   logic               w_locked;
   logic [SEL_W-1:0]   w_req;
   logic               w_req_ok;
   logic               w_start;
   logic [31:0]        w_status;
   logic [31:0]        w_ctrl_rd;
   logic               w_unused_ok;

   // Sources padded out to the full select range so the mux index width matches.
   logic [WIDTH-1:0] w_src_o_arr  [2**SEL_W];
   logic [WIDTH-1:0] w_src_oe_arr [2**SEL_W];

   for (genvar k = 0; k < 2**SEL_W; k++) begin : g_src
      if (k < NUM_SRC) begin : g_used
         assign w_src_o_arr[k]  = src_o[k*WIDTH +: WIDTH];
         assign w_src_oe_arr[k] = src_oe[k*WIDTH +: WIDTH];
      end else begin : g_unused
         assign w_src_o_arr[k]  = '0;
         assign w_src_oe_arr[k] = '0;
      end
   end

   assign src_i = {NUM_SRC{pad_i}};

   assign w_adr_ctrl = (wbs_adr_i == BASE_ADR);
   assign w_acc      = wbs_stb_i & wbs_cyc_i & (w_adr_ctrl | (wbs_adr_i == c_stat_adr)) & ~r_ack;
   assign w_ctrl_wr  = w_acc & wbs_we_i & w_adr_ctrl & wbs_sel_i[0] & ~w_locked;
   assign w_req      = wbs_dat_i[SEL_W-1:0];
   assign w_req_ok   = ({1'b0, w_req} < c_num_src);
   assign w_start    = w_ctrl_wr & w_req_ok & ((w_req != r_active_sel) | (r_state != c_st_active));

`ifdef V_LINE_SW_CFG_LOCK_EN
   logic r_lock;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         r_lock <= 1'b0;
      else if (w_ctrl_wr & wbs_sel_i[3] & wbs_dat_i[31])
         r_lock <= 1'b1;
   end

   assign w_locked = r_lock;
`else
   assign w_locked = 1'b0;
`endif

   assign w_unused_ok = &{1'b0, wbs_sel_i, wbs_dat_i};

   always_comb begin
      w_status                 = '0;
      w_status[0]              = busy;
      w_status[1]              = r_err;
      w_status[2]              = w_locked;
      w_status[8 +: SEL_W]     = r_active_sel;
      w_ctrl_rd                = '0;
      w_ctrl_rd[SEL_W-1:0]     = r_pending;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_acc;
         r_dat <= (w_acc & ~wbs_we_i) ? (w_adr_ctrl ? w_ctrl_rd : w_status) : '0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_err     <= 1'b0;
         r_pending <= c_reset_sel;
      end else if (w_ctrl_wr) begin
         r_err <= ~w_req_ok;
         if (w_req_ok)
            r_pending <= w_req;
      end
   end

   // Any accepted request while busy restarts the full settle window.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state      <= c_st_active;
         r_cnt        <= '0;
         r_active_sel <= c_reset_sel;
      end else begin
         case (r_state)
            c_st_active: begin
               if (w_start) begin
                  r_state <= c_st_quiesce;
                  r_cnt   <= c_cnt_load;
               end
            end
            c_st_quiesce: begin
               if (w_start)
                  r_cnt <= c_cnt_load;
               else if (r_cnt <= c_cnt_one)
                  r_state <= c_st_swap;
               else
                  r_cnt <= r_cnt - c_cnt_one;
            end
            c_st_swap: begin
               if (w_start) begin
                  r_state <= c_st_quiesce;
                  r_cnt   <= c_cnt_load;
               end else begin
                  r_active_sel <= r_pending;
                  r_state      <= c_st_active;
               end
            end
            default: r_state <= c_st_active;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_pad_o  <= '0;
         r_pad_oe <= '0;
      end else begin
         r_pad_o  <= w_src_o_arr[r_active_sel];
         r_pad_oe <= (r_state == c_st_active) ? w_src_oe_arr[r_active_sel] : '0;
      end
   end

   assign busy       = (r_state != c_st_active);
   assign active_sel = r_active_sel;
   assign pad_o      = r_pad_o;
   assign pad_oe     = r_pad_oe;
   assign wbs_ack_o  = r_ack;
   assign wbs_dat_o  = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_v_line_sw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_v_line_sw                                                    |
// | Purpose  : Directed plus randomized bench for v_line_sw with a             |
// |            countdown-based reference model.                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_v_line_sw;
   localparam int          NUM_SRC    = 4;
   localparam int          WIDTH      = 14;
   localparam int          SEL_W      = 4;
   localparam logic [31:0] BASE       = 32'h3000_0000;
   localparam int          SETTLE     = 4;
   localparam int          SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int          RESET_SEL  = 0;
`ifdef V_LINE_SW_CFG_LOCK_EN
   localparam bit          LOCK_EN    = 1'b1;
`else
   localparam bit          LOCK_EN    = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]               sel = 4'h0;
   logic [31:0]              dat_i = '0, adr = '0;
   logic                     ack;
   logic [31:0]              dat_o;
   logic [NUM_SRC*WIDTH-1:0] src_o = '0, src_oe = '0, src_i;
   logic [WIDTH-1:0]         pad_i = '0, pad_o, pad_oe;
   logic                     busy;
   logic [SEL_W-1:0]         active_sel;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   v_line_sw #(
      .NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .SEL_W(SEL_W), .BASE_ADR(BASE),
      .SETTLE_CYCLES(SETTLE), .RESET_SEL(RESET_SEL)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .src_o(src_o), .src_oe(src_oe), .pad_i(pad_i), .src_i(src_i),
      .pad_o(pad_o), .pad_oe(pad_oe), .busy(busy), .active_sel(active_sel)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a switchover is "m_left cycles of busy remaining"; the
   // source changes when that reaches zero, and pads are off while it is nonzero.
   int               m_active = RESET_SEL, m_pending = RESET_SEL, m_left = 0, m_req;
   bit               m_err = 0, m_lock = 0, m_ack = 0, m_acc, m_hit_ctrl, m_restart;
   logic [31:0]      m_dat = '0, m_st;
   logic [WIDTH-1:0] m_pad_o = '0, m_pad_oe = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = RESET_SEL; m_pending = RESET_SEL; m_left = 0;
         m_err = 0; m_lock = 0; m_ack = 0; m_dat = '0; m_pad_o = '0; m_pad_oe = '0;
      end else begin
         m_hit_ctrl = (adr == BASE);
         m_acc      = stb && cyc && (m_hit_ctrl || adr == BASE + 32'd4) && !m_ack;
         m_st       = '0;
         m_st[0]    = (m_left != 0);
         m_st[1]    = m_err;
         m_st[2]    = m_lock;
         m_st[8 +: SEL_W] = m_active[SEL_W-1:0];
         m_ack      = m_acc;
         m_dat      = (m_acc && !we) ? (m_hit_ctrl ? 32'(m_pending) : m_st) : '0;
         m_pad_o    = src_o[m_active*WIDTH +: WIDTH];
         m_pad_oe   = (m_left == 0) ? src_oe[m_active*WIDTH +: WIDTH] : '0;
         m_restart  = 0;
         if (m_acc && we && m_hit_ctrl && sel[0] && !m_lock) begin
            m_req = int'(dat_i[SEL_W-1:0]);
            if (LOCK_EN && sel[3] && dat_i[31]) m_lock = 1;
            if (m_req >= NUM_SRC) m_err = 1;
            else begin
               m_err = 0;
               if (m_req != m_active || m_left != 0) begin
                  m_left = SETTLE_EFF + 1;
                  m_restart = 1;
               end
               m_pending = m_req;
            end
         end
         if (!m_restart && m_left != 0) begin
            m_left--;
            if (m_left == 0) m_active = m_pending;
         end
      end
   end

   always @(negedge clk) begin
      chk("ack", 64'(ack), 64'(m_ack));
      chk("dat_o", 64'(dat_o), 64'(m_dat));
      chk("pad_o", 64'(pad_o), 64'(m_pad_o));
      chk("pad_oe", 64'(pad_oe), 64'(m_pad_oe));
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("active_sel", 64'(active_sel), 64'(m_active));
      chk("src_i", 64'(src_i), 64'({NUM_SRC{pad_i}}));
   end

   task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output bit acked);
      @(negedge clk); #1;
      stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
      acked = 0; rd = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack) begin acked = 1; rd = dat_o; break; end
      end
      #1 stb = 0; cyc = 0; we = 0;
   endtask

   function automatic logic [WIDTH-1:0] so(input int k);
      return WIDTH'(14'h1234 + k * 14'h0111);
   endfunction

   function automatic logic [WIDTH-1:0] soe(input int k);
      return WIDTH'(14'h3FFF >> k);
   endfunction

   logic [31:0] rd;
   bit          ok;
   int          n_busy, n_off;
   bit          seen1, got_first;
   logic [WIDTH-1:0] first_oe;

   initial begin
      for (int k = 0; k < NUM_SRC; k++) begin
         src_o[k*WIDTH +: WIDTH]  = so(k);
         src_oe[k*WIDTH +: WIDTH] = soe(k);
      end
      #2 rst = 1;
      repeat (3) @(negedge clk);
      chk("rst_pad_oe", 64'(pad_oe), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      #1 rst = 0;
      repeat (2) @(negedge clk);
      chk("init_pad_o", 64'(pad_o), 64'h1234);
      chk("init_pad_oe", 64'(pad_oe), 64'h3FFF);
      chk("init_active", 64'(active_sel), 64'h0);

      // Switch to source 2: five cycles busy, five cycles pads off.
      wb(1, BASE, 32'd2, 4'hF, rd, ok);
      chk("sw2_ack", 64'(ok), 64'h1);
      n_busy = 0; n_off = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy) n_busy++;
         if (pad_oe == '0) n_off++;
         @(negedge clk);
      end
      chk("sw2_busy_cycles", 64'(n_busy), 64'd5);
      chk("sw2_off_cycles", 64'(n_off), 64'd5);
      chk("sw2_active", 64'(active_sel), 64'd2);
      chk("sw2_pad_o", 64'(pad_o), 64'(so(2)));

      // Retarget 1 -> 3 mid-settle: source 1 never reaches the pads.
      wb(1, BASE, 32'd1, 4'hF, rd, ok);
      wb(1, BASE, 32'd3, 4'hF, rd, ok);
      seen1 = 0; n_off = 0; got_first = 0; first_oe = '0;
      for (int i = 0; i < 12; i++) begin
         if (pad_o == so(1)) seen1 = 1;
         if (pad_oe == '0) n_off++;
         else if (!got_first) begin got_first = 1; first_oe = pad_oe; end
         @(negedge clk);
      end
      chk("retarget_src1_seen", 64'(seen1), 64'h0);
      chk("retarget_off_cycles", 64'(n_off), 64'd6);
      chk("retarget_first_oe", 64'(first_oe), 64'(soe(3)));
      chk("retarget_active", 64'(active_sel), 64'd3);

      // Out-of-range request sets err; a valid one clears it.
      wb(1, BASE, 32'd5, 4'hF, rd, ok);
      chk("bad_req_ack", 64'(ok), 64'h1);
      wb(0, BASE + 32'd4, 32'd0, 4'hF, rd, ok);
      chk("bad_req_status", 64'(rd), 64'h0000_0302);
      wb(1, BASE, 32'd3, 4'hF, rd, ok);
      wb(0, BASE + 32'd4, 32'd0, 4'hF, rd, ok);
      chk("err_clear_status", 64'(rd), 64'h0000_0300);

      wb(0, BASE + 32'd8, 32'd0, 4'hF, rd, ok);
      chk("bad_adr_noack", 64'(ok), 64'h0);

      wb(1, BASE, 32'd0, 4'hF, rd, ok);
      wb(0, BASE + 32'd4, 32'd0, 4'hF, rd, ok);
      chk("mid_switch_busy_bit", 64'(rd[0]), 64'h1);
      wb(0, BASE, 32'd0, 4'hF, rd, ok);
      chk("ctrl_read_pending", 64'(rd), 64'h0);
      repeat (12) @(negedge clk);

      // Lock bit: with the feature off it is ignored.
      wb(1, BASE, 32'h8000_0001, 4'hF, rd, ok);
      repeat (12) @(negedge clk);
      chk("lock_wr_active", 64'(active_sel), 64'd1);
      wb(0, BASE + 32'd4, 32'd0, 4'hF, rd, ok);
      chk("lock_status_bit", 64'(rd[2]), 64'(LOCK_EN));
      wb(1, BASE, 32'd2, 4'hF, rd, ok);
      chk("locked_wr_ack", 64'(ok), 64'h1);
      n_busy = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy) n_busy++;
         @(negedge clk);
      end
      chk("locked_busy_cycles", 64'(n_busy), LOCK_EN ? 64'd0 : 64'd5);
      chk("locked_active", 64'(active_sel), LOCK_EN ? 64'd1 : 64'd2);

      // Randomized traffic with two asynchronous reset pulses.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c == 0 || c == 2000) begin
            #2 rst = 1;
            #4 rst = 0;
         end else begin
            #1;
         end
         for (int k = 0; k < NUM_SRC; k++) begin
            src_o[k*WIDTH +: WIDTH]  = WIDTH'($urandom);
            src_oe[k*WIDTH +: WIDTH] = WIDTH'($urandom);
         end
         pad_i = WIDTH'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            stb = ($urandom_range(0, 7) != 0);
            cyc = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 7))
               0, 1, 2, 3: adr = BASE;
               4, 5:       adr = BASE + 32'd4;
               6:          adr = BASE + 32'd8;
               default:    adr = $urandom;
            endcase
            we    = ($urandom_range(0, 3) != 0);
            sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            dat_i = {($urandom_range(0, 63) == 0), 27'($urandom), 4'($urandom_range(0, 5))};
         end else begin
            stb = 0; cyc = 0; we = 0;
         end
      end
      @(negedge clk); #1 stb = 0; cyc = 0;
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
